hex_scan_ctrl: RTL and testbench

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

---
 rtl/hex_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Scanned 8-digit hex display controller: decodes one nibble per CLK_DIV clocks
// into a staging buffer and commits the whole frame to hex_out in a single edge.

module hexdec (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Active-low gfedcba segment codes for 0..F
    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

module hex_scan_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        clr,
    output logic [55:0] hex_out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_SCAN    = 2'd1;
    localparam logic [1:0]  ST_COMMIT  = 2'd2;
    localparam logic [15:0] PRESC_LOAD = 16'(CLK_DIV - 1);
    localparam logic [6:0]  SEG_OFF    = 7'b1111111;

    logic [1:0]  state_r;
    logic [31:0] shadow_r;
    logic [2:0]  idx_r;
    logic [15:0] presc_r;
    logic        lz_r;
    logic [55:0] stage_r;
    logic [55:0] hex_r;
    logic        done_r;

    logic        accept_s;
    logic        step_s;
    logic [3:0]  nib_s;
    logic [6:0]  dec_s;
    logic [6:0]  digit_s;

    assign din_ready = (state_r == ST_IDLE) && !clr;
    assign accept_s  = din_valid && din_ready;
    assign step_s    = (state_r == ST_SCAN) && (presc_r == 16'd0);
    assign nib_s     = shadow_r[{idx_r, 2'b00} +: 4];
    assign busy      = (state_r != ST_IDLE);
    assign hex_out   = hex_r;
    assign done      = done_r;

    hexdec u_hexdec (
        .nib (nib_s),
        .seg (dec_s)
    );

    // Blank leading zeros above the first nonzero nibble; digit 0 always shows
    always_comb begin
        digit_s = dec_s;
        if ((BLANK_LZ != 0) && lz_r && (nib_s == 4'd0) && (idx_r != 3'd0)) begin
            digit_s = SEG_OFF;
        end else begin
            digit_s = dec_s;
        end
    end

    // Scan sequencer: accept, prescaled digit stepping, commit handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            shadow_r <= 32'd0;
            idx_r    <= 3'd7;
            presc_r  <= 16'd0;
            lz_r     <= 1'b0;
            done_r   <= 1'b0;
        end else if (clr) begin
            state_r  <= ST_IDLE;
            idx_r    <= 3'd7;
            presc_r  <= 16'd0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        shadow_r <= din;
                        idx_r    <= 3'd7;
                        lz_r     <= 1'b1;
                        presc_r  <= PRESC_LOAD;
                        state_r  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    done_r <= 1'b0;
                    if (step_s) begin
                        presc_r <= PRESC_LOAD;
                        idx_r   <= idx_r - 3'd1;
                        lz_r    <= lz_r && (nib_s == 4'd0);
                        if (idx_r == 3'd0) begin
                            state_r <= ST_COMMIT;
                        end
                    end else begin
                        presc_r <= presc_r - 16'd1;
                    end
                end
                ST_COMMIT: begin
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Staging buffer receives one decoded digit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= {8{SEG_OFF}};
        end else if (clr) begin
            stage_r <= {8{SEG_OFF}};
        end else if (step_s) begin
            for (int i = 0; i < 8; i++) begin
                if (idx_r == 3'(i)) begin
                    stage_r[7*i +: 7] <= digit_s;
                end
            end
        end
    end

    // Displayed frame only changes wholesale, so the display never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_r <= {8{SEG_OFF}};
        end else if (clr) begin
            hex_r <= {8{SEG_OFF}};
        end else if (state_r == ST_COMMIT) begin
            hex_r <= stage_r;
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: two instances (CLK_DIV=4/BLANK_LZ=1 and CLK_DIV=1/BLANK_LZ=0)
// checked against an arithmetic display model with directed and random frames.

module tb_hex_scan_ctrl;

    localparam logic [6:0] OFF = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic [31:0] din_a, din_b;
    logic        valid_a, valid_b, clr_a, clr_b;
    logic        ready_a, ready_b, busy_a, busy_b, done_a, done_b;
    logic [55:0] hex_a, hex_b;

    int total;
    int bad;

    hex_scan_ctrl #(.CLK_DIV(4), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
        .clr(clr_a), .hex_out(hex_a), .busy(busy_a), .done(done_a)
    );

    hex_scan_ctrl #(.CLK_DIV(1), .BLANK_LZ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
        .clr(clr_b), .hex_out(hex_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Expected frame: every digit above the most significant nonzero nibble is blank
    function automatic logic [55:0] model(input logic [31:0] v, input bit blz);
        logic [55:0] r;
        int msd;
        msd = 0;
        for (int i = 0; i < 8; i++) begin
            if (((v >> (4 * i)) & 32'hF) != 32'd0) msd = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (blz && i > msd) r[7*i +: 7] = OFF;
            else r[7*i +: 7] = seg7(4'((v >> (4 * i)) & 32'hF));
        end
        return r;
    endfunction

    function automatic logic [55:0] hx(input bit s);
        return s ? hex_b : hex_a;
    endfunction
    function automatic logic rdy(input bit s);
        return s ? ready_b : ready_a;
    endfunction
    function automatic logic dn(input bit s);
        return s ? done_b : done_a;
    endfunction
    function automatic logic bsy(input bit s);
        return s ? busy_b : busy_a;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic [31:0] d, input logic v, input logic c);
        if (s) begin
            din_b = d; valid_b = v; clr_b = c;
        end else begin
            din_a = d; valid_a = v; clr_a = c;
        end
    endtask

    // Offer one frame, measure edges until done and check the committed image
    task automatic run_frame(input bit s, input logic [31:0] val, input bit hold,
                             input logic [55:0] exp, input string tag);
        int cnt;
        int lat;
        bit stable;
        bit rdy_low;
        logic [55:0] prev;
        lat = s ? 9 : 33;
        prev = hx(s);
        drive(s, val, 1'b1, 1'b0);
        check({tag, "_ready_before"}, 64'(rdy(s)), 64'd1);
        tick();
        if (!hold) drive(s, val, 1'b0, 1'b0);
        cnt = 0;
        stable = 1'b1;
        rdy_low = 1'b1;
        while (cnt < lat + 10) begin
            if (hold) drive(s, 32'($urandom), 1'b1, 1'b0);
            tick();
            cnt++;
            if (dn(s) === 1'b1) break;
            if (hx(s) !== prev) stable = 1'b0;
            if (rdy(s) !== 1'b0) rdy_low = 1'b0;
        end
        drive(s, val, 1'b0, 1'b0);
        check({tag, "_latency"}, 64'(cnt), 64'(lat));
        check({tag, "_hex"}, 64'(hx(s)), 64'(exp));
        check({tag, "_no_tear"}, 64'(stable), 64'd1);
        check({tag, "_ready_low_while_busy"}, 64'(rdy_low), 64'd1);
        check({tag, "_ready_after"}, 64'(rdy(s)), 64'd1);
        check({tag, "_busy_after"}, 64'(bsy(s)), 64'd0);
        tick();
        check({tag, "_done_one_cycle"}, 64'(dn(s)), 64'd0);
        check({tag, "_hex_held"}, 64'(hx(s)), 64'(exp));
    endtask

    initial begin
        logic [31:0] v;
        bit saw_done;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd0, 1'b0, 1'b0);
        #12;
        check("reset_hex_a", 64'(hex_a), 64'({8{OFF}}));
        check("reset_hex_b", 64'(hex_b), 64'({8{OFF}}));
        check("reset_busy_a", 64'(busy_a), 64'd0);
        check("reset_done_a", 64'(done_a), 64'd0);
        check("reset_busy_b", 64'(busy_b), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_reset_ready_a", 64'(ready_a), 64'd1);
        check("post_reset_ready_b", 64'(ready_b), 64'd1);

        run_frame(1'b0, 32'h1234ABCD, 1'b0,
                  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, "golden_1234abcd");
        run_frame(1'b0, 32'h000000F0, 1'b0, {{6{OFF}}, 7'b0001110, 7'b1000000}, "lz_f0");
        run_frame(1'b0, 32'h00000000, 1'b0, {{7{OFF}}, 7'b1000000}, "lz_zero");
        run_frame(1'b0, 32'h00C0FFEE, 1'b1, model(32'h00C0FFEE, 1'b1), "hold_changing_din");

        for (int k = 0; k < 6; k++) begin
            v = 32'($urandom) >> (4 * $urandom_range(0, 7));
            run_frame(1'b0, v, (k == 3), model(v, 1'b1), "rand_a");
        end

        // Abort a scan with clr sampled at E0+10
        run_frame(1'b0, 32'h89ABCDEF, 1'b0, model(32'h89ABCDEF, 1'b1), "pre_clr");
        drive(1'b0, 32'h55555555, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h55555555, 1'b0, 1'b0);
        repeat (9) tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        check("clr_ready_low", 64'(ready_a), 64'd0);
        tick();
        check("clr_hex_off", 64'(hex_a), 64'({8{OFF}}));
        check("clr_busy", 64'(busy_a), 64'd0);
        check("clr_done", 64'(done_a), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("clr_ready_after", 64'(ready_a), 64'd1);
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done_a === 1'b1) saw_done = 1'b1;
        end
        check("clr_no_done_later", 64'(saw_done), 64'd0);

        drive(1'b0, 32'h12345678, 1'b1, 1'b1);
        tick();
        check("clr_vs_valid_busy", 64'(busy_a), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check("clr_vs_valid_busy2", 64'(busy_a), 64'd0);
        check("clr_vs_valid_hex", 64'(hex_a), 64'({8{OFF}}));

        run_frame(1'b1, 32'h00000000, 1'b0, {8{7'b1000000}}, "nolz_zero");
        for (int k = 0; k < 4; k++) begin
            v = 32'($urandom) >> (4 * $urandom_range(0, 7));
            run_frame(1'b1, v, 1'b0, model(v, 1'b0), "rand_b");
        end

        // Asynchronous reset in the middle of a scan
        drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        drive(1'b0, 32'hCAFE0001, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_hex_b", 64'(hex_b), 64'({8{OFF}}));
        check("arst_busy_b", 64'(busy_b), 64'd0);
        check("arst_done_b", 64'(done_b), 64'd0);
        check("arst_busy_a", 64'(busy_a), 64'd0);
        #10;
        rst_n = 1'b1;
        tick();
        check("arst_no_done_a", 64'(done_a), 64'd0);
        run_frame(1'b1, 32'h0BADF00D, 1'b0, model(32'h0BADF00D, 1'b0), "after_arst_b");
        run_frame(1'b0, 32'h00000700, 1'b0, model(32'h00000700, 1'b1), "after_arst_a");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
